sum_bcd_display: RTL and testbench

Sequential binary-to-BCD converter and two-digit seven-segment driver for the 4-bit adder lab datapath. It captures the adder's 6-bit binary sum on a load strobe and converts it iteratively using shift-and-add-3 (double dabble), one bit per clock. It then registers active-low segment patterns for HEX1 (tens) and HEX0 (ones). It is the decode/display end of the path whose encode end produces the binary sum from SW operands.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/sum_bcd_display.sv | 108 ++++++++++
 tb/tb_sum_bcd_display.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (active-low, bit6=g .. bit0=a) and the
// converter state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern; anything
// outside 0-9 shows blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Captures the adder's binary sum, converts it to two BCD digits by
// shift-and-add-3 (one bit per clock) and registers the HEX1/HEX0 patterns.
//
// state  | meaning
// IDLE   | waiting for load; outputs hold the last result
// CONV   | one add-3/shift step per clock, counter counts down to 0
// UPDATE | scratch digits copied to outputs, done pulses next cycle
module sum_bcd_display
  import seg7_pkg::*;
#(
  parameter int SUM_W    = 6,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX0
);

  localparam int CNT_W = $clog2(SUM_W + 1);
  localparam int SR_W  = SUM_W + 8;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [3:0]        scr_tens, scr_ones;
  logic [3:0]        adj_tens, adj_ones;
  logic              start, step, commit;
  logic [6:0]        seg_tens, seg_ones;

  assign scr_tens = sr[SR_W-1 -: 4];
  assign scr_ones = sr[SR_W-5 -: 4];

  always_comb begin
    adj_tens = (scr_tens >= 4'd5) ? scr_tens + 4'd3 : scr_tens;
    adj_ones = (scr_ones >= 4'd5) ? scr_ones + 4'd3 : scr_ones;
    sr_adj   = {adj_tens, adj_ones, sr[SUM_W-1:0]};
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONV;
      CONV:    if (cnt == CNT_W'(1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    start  = (state == IDLE) && load;
    step   = (state == CONV);
    commit = (state == UPDATE);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sr  <= '0;
      cnt <= '0;
    end else if (start) begin
      sr  <= {8'd0, sum_in};
      cnt <= CNT_W'(SUM_W);
    end else if (step) begin
      sr  <= sr_adj << 1;
      cnt <= cnt - CNT_W'(1);
    end
  end

  seg7_decode u_dec_tens (.digit(scr_tens), .seg(seg_tens));
  seg7_decode u_dec_ones (.digit(scr_ones), .seg(seg_ones));

  // Digits and segments only move on commit so the display never shows
  // partially converted values.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      done     <= 1'b0;
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
      HEX1     <= SEG_BLANK;
      HEX0     <= SEG_BLANK;
    end else begin
      done <= commit;
      if (commit) begin
        bcd_tens <= scr_tens;
        bcd_ones <= scr_ones;
        HEX1     <= (BLANK_LZ && (scr_tens == 4'd0)) ? SEG_BLANK : seg_tens;
        HEX0     <= seg_ones;
      end
    end
  end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Directed plus random bench for sum_bcd_display; expected digits come from
// /10 and %10 arithmetic and a segment lookup table.
module tb_sum_bcd_display;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [5:0] sum_in;
  logic       load;

  logic       busy, done, busy_nb, done_nb;
  logic [3:0] bcd_tens, bcd_ones, bcd_tens_nb, bcd_ones_nb;
  logic [6:0] HEX1, HEX0, HEX1_nb, HEX0_nb;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic [3:0] exp_tens, exp_ones;
  logic [6:0] exp_h1, exp_h0, exp_h1_nb;

  sum_bcd_display dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .sum_in(sum_in), .load(load),
    .busy(busy), .done(done), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .HEX1(HEX1), .HEX0(HEX0)
  );

  sum_bcd_display #(.SUM_W(6), .BLANK_LZ(1'b0)) dut_nb (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .sum_in(sum_in), .load(load),
    .busy(busy_nb), .done(done_nb), .bcd_tens(bcd_tens_nb), .bcd_ones(bcd_ones_nb),
    .HEX1(HEX1_nb), .HEX0(HEX0_nb)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_reset();
    exp_tens  = 4'd0;
    exp_ones  = 4'd0;
    exp_h1    = 7'h7f;
    exp_h0    = 7'h7f;
    exp_h1_nb = 7'h7f;
  endtask

  task automatic expect_value(input int v);
    int t, o;
    t = v / 10;
    o = v % 10;
    exp_tens  = 4'(t);
    exp_ones  = 4'(o);
    exp_h0    = seg_tab[o];
    exp_h1_nb = seg_tab[t];
    exp_h1    = (t == 0) ? 7'h7f : seg_tab[t];
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".tens"},    bcd_tens,    exp_tens);
    check({tag, ".ones"},    bcd_ones,    exp_ones);
    check({tag, ".hex1"},    HEX1,        exp_h1);
    check({tag, ".hex0"},    HEX0,        exp_h0);
    check({tag, ".nb_tens"}, bcd_tens_nb, exp_tens);
    check({tag, ".nb_ones"}, bcd_ones_nb, exp_ones);
    check({tag, ".nb_hex1"}, HEX1_nb,     exp_h1_nb);
    check({tag, ".nb_hex0"}, HEX0_nb,     exp_h0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50); #1;
      check("idle.busy", busy, 1'b0);
      check("idle.done", done, 1'b0);
      check("idle.nb_done", done_nb, 1'b0);
      check_outs("idle");
    end
  endtask

  // Presents v with load at the next edge, then drives next_v/hold while the
  // conversion runs; outputs must hold the previous result until done.
  task automatic run_conv(input int v, input int next_v, input bit hold);
    int  lat;
    bit  got;
    @(negedge CLOCK_50);
    sum_in = 6'(v);
    load   = 1'b1;
    @(posedge CLOCK_50); #1;
    check("cap.busy", busy, 1'b1);
    check("cap.done", done, 1'b0);
    sum_in = 6'(next_v);
    load   = hold;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge CLOCK_50); #1;
      if (done) begin
        got = 1'b1;
        lat = c;
      end else begin
        check("conv.busy", busy, 1'b1);
        check_outs("conv.hold");
      end
    end
    check("latency", lat, 7);
    check("nb.done", done_nb, 1'b1);
    check("done.busy", busy, 1'b0);
    expect_value(v);
    check_outs("result");
  endtask

  initial begin
    RESET_N = 1'b0;
    load    = 1'b0;
    sum_in  = 6'd0;
    expect_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check_outs("rst");
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    idle_cycles(2);

    run_conv(31, 12, 1'b0);
    idle_cycles(2);
    run_conv(0, 45, 1'b0);
    idle_cycles(1);

    // load held high across the conversion; sum_in already 9 when it ends
    run_conv(63, 9, 1'b1);
    run_conv(9, 50, 1'b0);
    idle_cycles(2);

    // reset part-way through converting 27
    @(negedge CLOCK_50);
    sum_in = 6'd27;
    load   = 1'b1;
    @(posedge CLOCK_50); #1;
    load = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("mid.busy_pre", busy, 1'b1);
    RESET_N = 1'b0;
    #1;
    expect_reset();
    check("mid.busy", busy, 1'b0);
    check("mid.done", done, 1'b0);
    check_outs("mid.rst");
    load   = 1'b1;
    sum_in = 6'd44;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("rstload.busy", busy, 1'b0);
    check_outs("rstload");
    @(negedge CLOCK_50);
    load    = 1'b0;
    RESET_N = 1'b1;
    idle_cycles(10);
    run_conv(27, 3, 1'b0);

    // back-to-back: second load on the cycle after done
    run_conv(14, 60, 1'b0);
    run_conv(5, 33, 1'b0);
    idle_cycles(1);

    for (int i = 0; i < 20; i++) begin
      run_conv(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b0);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
